// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer.
package btb_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Two-bit saturating direction counter step.
    function automatic ctr_t ctr_next(ctr_t c, logic taken);
        ctr_t r;
        if (taken) begin
            r = (c == ST) ? ST : ctr_t'(c + 2'd1);
        end else begin
            r = (c == SNT) ? SNT : ctr_t'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// Generic saturating up/down counter with enable and synchronous clear.
module btb_sat_ctr #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         up_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority, then saturating step in the chosen direction.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (up_i && (cnt_q != {W{1'b1}})) begin
                cnt_d = cnt_q + W'(1);
            end else if (!up_i && (cnt_q != '0)) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/btb_2bit_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, allocate-on-taken and
// mispredict statistics. Optional write-through bypass: define BTB_FWD_EN.
module btb_2bit_predictor
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              up_valid,
    input  logic [ADDR_W-1:0] up_pc,
    input  logic              up_taken,
    input  logic [ADDR_W-1:0] up_target,
    input  logic              up_mispred,
    output logic [STAT_W-1:0] stat_updates,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    ctr_t               ctr_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [ADDR_W-1:0]  dest_q [ENTRIES];

    logic [IDX_W-1:0]   l_idx, u_idx;
    logic [TAG_W-1:0]   l_tag, u_tag;
    logic               u_hit;
    logic               tbl_wr;

    logic               e_valid_d;
    ctr_t               e_ctr_d;
    logic [TAG_W-1:0]   e_tag_d;
    logic [ADDR_W-1:0]  e_dest_d;

    logic               r_valid;
    ctr_t               r_ctr;
    logic [TAG_W-1:0]   r_tag;
    logic [ADDR_W-1:0]  r_dest;

    logic               unused_pc_bits;

    assign l_idx = lk_pc[IDX_W+1:2];
    assign l_tag = lk_pc[ADDR_W-1:IDX_W+2];
    assign u_idx = up_pc[IDX_W+1:2];
    assign u_tag = up_pc[ADDR_W-1:IDX_W+2];

    // Byte-offset bits never address the table.
    assign unused_pc_bits = ^{lk_pc[1:0], up_pc[1:0]};

    // Post-update contents of the entry addressed by the resolved branch.
    always_comb begin
        u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        e_valid_d = valid_q[u_idx];
        e_ctr_d   = ctr_q[u_idx];
        e_tag_d   = tag_q[u_idx];
        e_dest_d  = dest_q[u_idx];
        tbl_wr    = 1'b0;
        if (up_valid) begin
            if (u_hit) begin
                tbl_wr  = 1'b1;
                e_ctr_d = ctr_next(ctr_q[u_idx], up_taken);
                if (up_taken) begin
                    e_dest_d = up_target;
                end
            end else if (up_taken) begin
                tbl_wr    = 1'b1;
                e_valid_d = 1'b1;
                e_ctr_d   = WT;
                e_tag_d   = u_tag;
                e_dest_d  = up_target;
            end
        end
    end

    // Valid bits and counters: reset to empty / weakly-not-taken, reset beats update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (tbl_wr) begin
            valid_q[u_idx] <= e_valid_d;
            ctr_q[u_idx]   <= e_ctr_d;
        end
    end

    // Tags and targets keep their contents across reset.
    always_ff @(posedge clk) begin
        if (rst_n && tbl_wr) begin
            tag_q[u_idx]  <= e_tag_d;
            dest_q[u_idx] <= e_dest_d;
        end
    end

    // Lookup read, optionally bypassing a same-index update in flight.
    always_comb begin
        r_valid = valid_q[l_idx];
        r_ctr   = ctr_q[l_idx];
        r_tag   = tag_q[l_idx];
        r_dest  = dest_q[l_idx];
`ifdef BTB_FWD_EN
        if (up_valid && (l_idx == u_idx)) begin
            r_valid = e_valid_d;
            r_ctr   = e_ctr_d;
            r_tag   = e_tag_d;
            r_dest  = e_dest_d;
        end
`endif
    end

    assign lk_hit    = r_valid && (r_tag == l_tag);
    assign lk_taken  = lk_hit && r_ctr[1];
    assign lk_target = lk_hit ? r_dest : '0;

    btb_sat_ctr #(.W(STAT_W)) u_stat_updates (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .en_i  (up_valid),
        .up_i  (1'b1),
        .cnt_o (stat_updates)
    );

    btb_sat_ctr #(.W(STAT_W)) u_stat_mispred (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .en_i  (up_valid && up_mispred),
        .up_i  (1'b1),
        .cnt_o (stat_mispred)
    );

endmodule

// File: tb/tb_btb_2bit_predictor.sv
// Scoreboard bench for btb_2bit_predictor (ENTRIES=16, ADDR_W=32, STAT_W=4).
module tb_btb_2bit_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] lk_pc;
    logic        lk_hit;
    logic        lk_taken;
    logic [31:0] lk_target;
    logic        up_valid;
    logic [31:0] up_pc;
    logic        up_taken;
    logic [31:0] up_target;
    logic        up_mispred;
    logic [3:0]  stat_updates;
    logic [3:0]  stat_mispred;

    btb_2bit_predictor #(.ENTRIES(16), .ADDR_W(32), .STAT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lk_pc        (lk_pc),
        .lk_hit       (lk_hit),
        .lk_taken     (lk_taken),
        .lk_target    (lk_target),
        .up_valid     (up_valid),
        .up_pc        (up_pc),
        .up_taken     (up_taken),
        .up_target    (up_target),
        .up_mispred   (up_mispred),
        .stat_updates (stat_updates),
        .stat_mispred (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [3:0]  upd;
        logic [3:0]  mis;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;
    logic  chk_v  = 1'b0;
    logic [3:0] m_upd = 4'd0;
    logic [3:0] m_mis = 4'd0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: pops one expectation per flagged cycle and compares.
    always @(negedge clk) begin
        if (chk_v) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got empty queue expected an entry");
            end else begin
                exp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                cmp(n, "hit",    32'(lk_hit),       32'(e.hit));
                cmp(n, "taken",  32'(lk_taken),     32'(e.taken));
                cmp(n, "target", lk_target,         e.tgt);
                cmp(n, "upd",    32'(stat_updates), 32'(e.upd));
                cmp(n, "mis",    32'(stat_mispred), 32'(e.mis));
            end
        end
    end

    // One cycle of stimulus; optionally queue the expected lookup/stat response.
    task automatic step(input logic rst, input logic [31:0] lpc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                        input logic um, input bit chk, input logic eh, input logic et,
                        input logic [31:0] etg, input string nm);
        @(posedge clk);
        #1;
        rst_n      = rst;
        lk_pc      = lpc;
        up_valid   = uv;
        up_pc      = upc;
        up_taken   = ut;
        up_target  = utgt;
        up_mispred = um;
        chk_v      = chk;
        if (chk) begin
            exp_q.push_back('{eh, et, etg, m_upd, m_mis});
            name_q.push_back(nm);
        end
        if (!rst) begin
            m_upd = 4'd0;
            m_mis = 4'd0;
        end else if (uv) begin
            if (m_upd != 4'hF) m_upd = m_upd + 4'd1;
            if (um && (m_mis != 4'hF)) m_mis = m_mis + 4'd1;
        end
    endtask

    // Update a branch while looking up an idle index-0 PC that never allocates.
    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic m, input string nm);
        step(1'b1, 32'h0, 1'b1, pc, t, tgt, m, 1'b1, 1'b0, 1'b0, 32'h0, nm);
    endtask

    task automatic look(input logic [31:0] pc, input logic eh, input logic et, input logic [31:0] etg, input string nm);
        step(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, eh, et, etg, nm);
    endtask

    task automatic do_reset();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; lk_pc = '0; up_valid = 1'b0; up_pc = '0;
        up_taken = 1'b0; up_target = '0; up_mispred = 1'b0;
        do_reset();
        do_reset();

        // Reset state and allocate-on-taken
        look(32'h1004, 1'b0, 1'b0, 32'h0, "reset_lookup");
        upd (32'h1004, 1'b1, 32'h2000, 1'b1, "alloc");
        look(32'h1004, 1'b1, 1'b1, 32'h2000, "alloc_hit");

        // Counter walk with saturation at both ends and target refresh on taken
        upd (32'h1004, 1'b0, 32'hDEAD, 1'b0, "nt1");
        look(32'h1004, 1'b1, 1'b0, 32'h2000, "wnt");
        upd (32'h1004, 1'b0, 32'hDEAD, 1'b1, "nt2");
        look(32'h1004, 1'b1, 1'b0, 32'h2000, "snt");
        upd (32'h1004, 1'b0, 32'hDEAD, 1'b0, "nt3");
        look(32'h1004, 1'b1, 1'b0, 32'h2000, "snt_sat");
        upd (32'h1004, 1'b1, 32'h2100, 1'b1, "t1");
        look(32'h1004, 1'b1, 1'b0, 32'h2100, "wnt_newtgt");
        upd (32'h1004, 1'b1, 32'h2100, 1'b0, "t2");
        look(32'h1004, 1'b1, 1'b1, 32'h2100, "wt");
        upd (32'h1004, 1'b1, 32'h2100, 1'b0, "t3");
        look(32'h1004, 1'b1, 1'b1, 32'h2100, "st");
        upd (32'h1004, 1'b1, 32'h2100, 1'b0, "t4");
        look(32'h1004, 1'b1, 1'b1, 32'h2100, "st_sat");
        upd (32'h1004, 1'b0, 32'hDEAD, 1'b1, "nt4");
        look(32'h1004, 1'b1, 1'b1, 32'h2100, "st_to_wt");
        upd (32'h1004, 1'b0, 32'hDEAD, 1'b0, "nt5");
        look(32'h1004, 1'b1, 1'b0, 32'h2100, "wt_to_wnt");
        upd (32'h1004, 1'b1, 32'h2200, 1'b0, "t5");
        look(32'h1004, 1'b1, 1'b1, 32'h2200, "wnt_to_wt");

        // Aliasing at index 1
        upd (32'h1044, 1'b0, 32'hBEEF, 1'b0, "alias_nt");
        look(32'h1004, 1'b1, 1'b1, 32'h2200, "alias_keep");
        look(32'h1044, 1'b0, 1'b0, 32'h0, "alias_miss");
        upd (32'h1044, 1'b1, 32'h5000, 1'b1, "alias_t");
        look(32'h1004, 1'b0, 1'b0, 32'h0, "alias_evicted");
        look(32'h1044, 1'b1, 1'b1, 32'h5000, "alias_new");

        // Strobe low: other update fields ignored
        step(1'b1, 32'h1044, 1'b0, 32'h1044, 1'b0, 32'h9999, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5000, "noup_same");
        look(32'h1044, 1'b1, 1'b1, 32'h5000, "noup_after");

        // Same-cycle lookup and allocate from an empty table
        do_reset();
`ifdef BTB_FWD_EN
        step(1'b1, 32'h3004, 1'b1, 32'h3004, 1'b1, 32'h4000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4000, "same_cycle");
`else
        step(1'b1, 32'h3004, 1'b1, 32'h3004, 1'b1, 32'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "same_cycle");
`endif
        look(32'h3004, 1'b1, 1'b1, 32'h4000, "same_cycle_next");

        // Reset beats a coincident update, then mispredict counter saturates
        step(1'b0, 32'h6008, 1'b1, 32'h6008, 1'b1, 32'h7000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "rst_upd");
        look(32'h6008, 1'b0, 1'b0, 32'h0, "rst_no_alloc");
        for (int i = 0; i < 17; i++) begin
            upd(32'h0, 1'b0, 32'h0, 1'b1, "mis_sat");
        end
        look(32'h6008, 1'b0, 1'b0, 32'h0, "stats_hold");
        look(32'h6008, 1'b0, 1'b0, 32'h0, "stats_hold2");

        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "idle");
        repeat (2) @(posedge clk);
        cmp("drain", "pending", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
